// File: rtl/rptr_empty_level.sv
// rptr_empty_level: read-side pointer, empty flag and occupancy tracking for
// an asynchronous FIFO.
// The write pointer (Gray code) is brought into the rclk domain through a
// SYNC_STAGES-deep flop chain. The block then derives the binary/Gray read
// pointers, a registered empty flag, the read-domain occupancy and an
// almost-empty flag.
// Optional feature: define RPTR_UFLOW_ERR_EN to build the sticky underflow
// flag rerr. When it is undefined, rerr is tied low and rclr_err is unused.
module rptr_empty_level #(
    parameter int unsigned ADDRSIZE    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic [ADDRSIZE:0]   rae_thresh,
    input  logic                rclr_err,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rerr
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  rq_wptr;
    logic [PW-1:0]                  rq_wbin;
    logic [PW-1:0]                  rbin;
    logic [PW-1:0]                  rbinnext;
    logic [PW-1:0]                  rgraynext;
    logic [PW-1:0]                  level_next;
    logic                           pop_c;
    logic                           rempty_next;
    logic                           raempty_next;

    // Write-pointer synchronizer; only the final stage is used downstream.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
        end
    end

    assign rq_wptr = sync_q[SYNC_STAGES-1];

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
    // all Gray bits at or above i.
    always_comb begin
        rq_wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rq_wbin[i] = ^(rq_wptr >> i);
        end
    end

    // Next read pointer and the flags/level it implies. Pops while empty
    // are dropped here so the pointers never move past the write pointer.
    always_comb begin
        pop_c        = rinc & ~rempty;
        rbinnext     = rbin + PW'(pop_c);
        rgraynext    = (rbinnext >> 1) ^ rbinnext;
        level_next   = rq_wbin - rbinnext;
        rempty_next  = (rgraynext == rq_wptr);
        raempty_next = (level_next <= rae_thresh);
    end

    // Read pointer, flag and level registers. The extra wrap bit keeps a
    // full FIFO (level 2^ADDRSIZE) distinct from an empty one.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= rempty_next;
            raempty <= raempty_next;
            rlevel  <= level_next;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

`ifdef RPTR_UFLOW_ERR_EN
    // Sticky underflow flag: a pop attempted while empty sets it, and a set
    // in the same cycle as a clear takes priority.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else if (rinc && rempty) begin
            rerr <= 1'b1;
        end else if (rclr_err) begin
            rerr <= 1'b0;
        end
    end
`else
    // Underflow reporting not built: constant output, clear input unused.
    logic unused_rclr_err;
    assign unused_rclr_err = rclr_err;
    assign rerr            = 1'b0;
`endif

endmodule

// File: doc/rptr_empty_level.md
RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 SHALL provide parameter: ADDRSIZE, default 4, memory address width (depth = 2^ADDRSIZE); legal range 2..12.
REQ-002 SHALL provide parameter: SYNC_STAGES, default 2, flop stages in the write-pointer synchronizer; legal range 2..4.
REQ-003 SHALL provide port: rclk  input  1  read-domain clock.
REQ-004 SHALL provide port: rrst_n  input  1  read-domain reset, asynchronous, active-low.
REQ-005 SHALL provide port: rinc  input  1  pop request.
REQ-006 SHALL provide port: wptr_gray  input  ADDRSIZE+1  write pointer (Gray code) from the write clock domain, unsynchronized.
REQ-007 SHALL provide port: rae_thresh  input  ADDRSIZE+1  almost-empty threshold, quasi-static.
REQ-008 SHALL provide port: rclr_err  input  1  clears the sticky underflow flag.
REQ-009 SHALL provide port: raddr  output  ADDRSIZE  binary memory read address.
REQ-010 SHALL provide port: rptr  output  ADDRSIZE+1  Gray read pointer, sent to the write domain.
REQ-011 SHALL provide port: rempty  output  1  FIFO empty.
REQ-012 SHALL provide port: raempty  output  1  almost empty (level <= rae_thresh).
REQ-013 SHALL provide port: rlevel  output  ADDRSIZE+1  registered occupancy as seen by the read domain, 0..2^ADDRSIZE.
REQ-014 SHALL provide port: rerr  output  1  sticky underflow flag.

Function
REQ-015 SHALL synchronize wptr_gray through SYNC_STAGES rclk flops; only the last stage (rq_wptr) feeds logic.
REQ-016 SHALL convert rq_wptr from Gray to binary (rq_wbin) combinationally.
REQ-017 SHALL hold binary pointer rbin (ADDRSIZE+1 bits); rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-018 SHALL compute rgraynext = (rbinnext >> 1) ^ rbinnext, and register rbin <= rbinnext and rptr <= rgraynext each rclk.
REQ-019 SHALL drive raddr = rbin[ADDRSIZE-1:0]; the MSB wrap bit is excluded.
REQ-020 SHALL register rempty <= (rgraynext == rq_wptr).
REQ-021 SHALL register rlevel <= (rq_wbin - rbinnext) modulo 2^(ADDRSIZE+1).
REQ-022 SHALL register raempty <= ((rq_wbin - rbinnext) <= rae_thresh), unsigned compare.
REQ-023 SHALL ignore rinc while rempty=1: pointers are unchanged and no memory-address advance occurs.
REQ-024 SHALL update rempty, raempty and rlevel one rclk after a change of rq_wptr; a wptr_gray change becomes visible SYNC_STAGES+1 rclk edges after it is sampled.
REQ-025 SHALL handle a simultaneous pop and write-pointer advance using the new values of both in the same cycle; rlevel stays unchanged when both move by one.
REQ-026 SHALL wrap pointer values from 2^(ADDRSIZE+1)-1 to 0 with no glitch in rempty, and only one rptr bit SHALL change per pop.
REQ-027 SHALL produce rempty=0 on a full FIFO (rlevel = 2^ADDRSIZE); a full FIFO never aliases to empty.

Reset
REQ-028 SHALL, on rrst_n low, asynchronously clear the synchronizer flops, rbin, rptr, raddr, rlevel and rerr to 0, and set rempty=1 and raempty=1.
REQ-029 SHALL make reset take effect mid-pop, with no partial pointer update; the first pop after reset is accepted on the first rclk edge with rrst_n high and rempty=0.

Configuration
REQ-030 SHALL provide macro RPTR_UFLOW_ERR_EN; when defined, rerr sets on the rclk edge after rinc=1 while rempty=1, and holds until rclr_err=1; if set and clear occur in the same cycle, set wins.
REQ-031 SHALL, when RPTR_UFLOW_ERR_EN is undefined, tie rerr to constant 0, ignore rclr_err and include no error logic.

Verification
REQ-032 SHALL verify reset: rrst_n low with wptr_gray=5'b00011 -> rempty=1, raempty=1, rlevel=0, rptr=0, rerr=0.
REQ-033 SHALL verify fill and latency: ADDRSIZE=4, SYNC_STAGES=2, wptr_gray steps 0->1 -> rempty falls 3 rclk edges later, rlevel=1.
REQ-034 SHALL verify drain: 16 entries written, rinc held high 16 cycles -> raddr 0..15, rempty=1 after the 16th pop, rlevel=0.
REQ-035 SHALL verify wrap: 40 write/pop pairs -> rptr passes through 5'b10000 and back to 0 with single-bit transitions, and rempty never falsely asserts while level > 0.
REQ-036 SHALL verify almost-empty: rae_thresh=3 with level falling 5->4->3 -> raempty rises on the cycle rlevel becomes 3.
REQ-037 SHALL verify underflow with RPTR_UFLOW_ERR_EN defined: rinc=1 while empty -> rerr=1 next cycle, rptr unchanged; rclr_err and rinc asserted together while empty -> rerr stays 1.
